// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-side front end of the register file.
// Merges in-order pipeline writeback (always wins) with buffered
// long-latency results (drained in idle slots) onto the single RF write
// port. It also keeps a busy scoreboard of destinations with long-latency
// results still outstanding.
module rf_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    // in-order pipeline writeback, no backpressure
    input  logic          pipe_we,
    input  logic [4:0]    pipe_waddr,
    input  logic [31:0]   pipe_wdata,
    // long-latency result offer
    input  logic          lu_valid,
    output logic          lu_ready,
    input  logic [4:0]    lu_waddr,
    input  logic [31:0]   lu_wdata,
    // long-latency issue (marks the destination busy)
    input  logic          issue_valid,
    input  logic [4:0]    issue_waddr,
    // RF write port
    output logic          rf_we,
    output logic [4:0]    rf_waddr,
    output logic [31:0]   rf_wdata,
    // status
    output logic [31:0]   busy_mask,
    output logic [AW:0]   fifo_count,
    output logic          sb_err
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_COUNT  = (AW + 1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    // ------------------------------------------------------------------
    // Result FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [4:0]    addr_mem_q [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          pipe_sel;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    // Output stage registers
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_waddr_q, rf_waddr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;

    // Scoreboard
    logic [31:0]   busy_q, busy_d;
    logic [31:0]   set_vec;
    logic [31:0]   clr_vec;
    logic          issue_set;
    logic          head_clr;
    logic          sb_err_q, sb_err_d;

    // Accept/drain decisions come from registered occupancy only, so a pop
    // in the same cycle never opens the door for a push into a full FIFO.
    assign fifo_full  = (count_q == FULL_COUNT);
    assign fifo_empty = (count_q == '0);
    assign lu_ready   = !rst && !fifo_full;
    assign push       = lu_valid && lu_ready;

    // Writes to $0 are dropped, so they never take the write port from the FIFO.
    assign pipe_sel   = pipe_we && (pipe_waddr != 5'd0);
    assign pop        = !pipe_sel && !fifo_empty;

    assign head_addr  = addr_mem_q[rd_ptr_q];
    assign head_data  = data_mem_q[rd_ptr_q];

    // FIFO storage write; no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= lu_waddr;
            data_mem_q[wr_ptr_q] <= lu_wdata;
        end
    end

    // Next-state for pointers and occupancy; pointers wrap modulo DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_COUNT;
            2'b01:   count_d = count_q - ONE_COUNT;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration and registered output stage
    // ------------------------------------------------------------------

    // Select the pipeline first, then the FIFO head; address/data hold when idle
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (pipe_sel) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pipe_waddr;
            rf_wdata_d = pipe_wdata;
        end else if (pop) begin
            // A $0 entry still drains, but must not write the register file
            rf_we_d    = (head_addr != 5'd0);
            rf_waddr_d = head_addr;
            rf_wdata_d = head_data;
        end
    end

    // Output stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign fifo_count = count_q;

    // ------------------------------------------------------------------
    // Busy scoreboard
    // ------------------------------------------------------------------
    assign issue_set = issue_valid && (issue_waddr != 5'd0);
    assign head_clr  = pop && (head_addr != 5'd0);

    // Per-register set/clear decode; a set in the same cycle beats a clear
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_busy
            assign set_vec[gi] = issue_set && (issue_waddr == 5'(gi));
            assign clr_vec[gi] = head_clr  && (head_addr   == 5'(gi));
            assign busy_d[gi]  = set_vec[gi] | (busy_q[gi] & ~clr_vec[gi]);
        end
    endgenerate

    // Flag a second issue to a register whose result is still outstanding,
    // unless that result is draining this very cycle
    always_comb begin
        sb_err_d = sb_err_q;
        if (issue_set && busy_q[issue_waddr] &&
            !(head_clr && (head_addr == issue_waddr))) begin
            sb_err_d = 1'b1;
        end
    end

    // Scoreboard and sticky error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign busy_mask = busy_q;
    assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed scenarios, a queue-based model
// compared on every falling edge, plus literal expectations per scenario.
module tb_rf_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          pipe_we;
    logic [4:0]    pipe_waddr;
    logic [31:0]   pipe_wdata;
    logic          lu_valid;
    logic          lu_ready;
    logic [4:0]    lu_waddr;
    logic [31:0]   lu_wdata;
    logic          issue_valid;
    logic [4:0]    issue_waddr;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic [31:0]   busy_mask;
    logic [AW:0]   fifo_count;
    logic          sb_err;

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_we     (pipe_we),
        .pipe_waddr  (pipe_waddr),
        .pipe_wdata  (pipe_wdata),
        .lu_valid    (lu_valid),
        .lu_ready    (lu_ready),
        .lu_waddr    (lu_waddr),
        .lu_wdata    (lu_wdata),
        .issue_valid (issue_valid),
        .issue_waddr (issue_waddr),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .busy_mask   (busy_mask),
        .fifo_count  (fifo_count),
        .sb_err      (sb_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [36:0] mq[$];          // {waddr, wdata} in arrival order
    bit          m_busy [32];
    bit          m_err  = 1'b0;
    bit          m_we   = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    always @(posedge clk) begin
        logic [36:0] ent;
        bit          popped;
        bit          can_push;
        if (rst) begin
            mq.delete();
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_err  = 1'b0;
            m_we   = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            can_push = (mq.size() < DEPTH);
            popped   = 1'b0;
            ent      = '0;
            if (pipe_we && pipe_waddr != 0) begin
                m_we = 1'b1; m_addr = pipe_waddr; m_data = pipe_wdata;
            end else if (mq.size() > 0) begin
                ent    = mq.pop_front();
                popped = 1'b1;
                m_we   = (ent[36:32] != 0);
                m_addr = ent[36:32];
                m_data = ent[31:0];
            end else begin
                m_we = 1'b0;
            end
            if (popped && ent[36:32] != 0) begin
                if (!(issue_valid && issue_waddr == ent[36:32]))
                    m_busy[ent[36:32]] = 1'b0;
            end
            if (issue_valid && issue_waddr != 0) begin
                if (m_busy[issue_waddr] && !(popped && ent[36:32] == issue_waddr))
                    m_err = 1'b1;
                m_busy[issue_waddr] = 1'b1;
            end
            if (lu_valid && can_push) mq.push_back({lu_waddr, lu_wdata});
        end
    end

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        for (int i = 0; i < 32; i++) m[i] = m_busy[i];
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, all outputs against the model
    always @(negedge clk) begin
        chk("cyc_rf_we", 32'(rf_we), 32'(m_we));
        if (m_we) begin
            chk("cyc_rf_waddr", 32'(rf_waddr), 32'(m_addr));
            chk("cyc_rf_wdata", rf_wdata, m_data);
        end
        chk("cyc_busy_mask", busy_mask, model_mask());
        chk("cyc_fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("cyc_lu_ready", 32'(lu_ready), 32'(!rst && mq.size() < DEPTH));
        chk("cyc_sb_err", 32'(sb_err), 32'(m_err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
        lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
        issue_valid = 1'b0; issue_waddr = '0;
        repeat (3) tick();
        chk("rst_lu_ready_low", 32'(lu_ready), 32'd0);
        rst = 1'b0;
        tick();

        // 1: idle after reset
        $display("T1 reset idle");
        chk("t1_rf_we", 32'(rf_we), 32'd0);
        chk("t1_lu_ready", 32'(lu_ready), 32'd1);
        chk("t1_busy", busy_mask, 32'd0);
        chk("t1_count", 32'(fifo_count), 32'd0);

        // 2: plain pipeline write
        $display("T2 pipe write $5=0x1234");
        pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'h1234;
        tick();
        pipe_we = 1'b0;
        chk("t2_rf_we", 32'(rf_we), 32'd1);
        chk("t2_rf_waddr", 32'(rf_waddr), 32'd5);
        chk("t2_rf_wdata", rf_wdata, 32'h1234);

        // 3: issue, later completion through the FIFO
        $display("T3 issue $8 then lu $8=0xDEAD");
        issue_valid = 1'b1; issue_waddr = 5'd8;
        tick();
        issue_valid = 1'b0;
        chk("t3_busy8_set", 32'(busy_mask[8]), 32'd1);
        tick(); tick();
        lu_valid = 1'b1; lu_waddr = 5'd8; lu_wdata = 32'hDEAD;
        tick();
        lu_valid = 1'b0;
        chk("t3_no_bypass_we", 32'(rf_we), 32'd0);
        chk("t3_count1", 32'(fifo_count), 32'd1);
        chk("t3_busy8_still", 32'(busy_mask[8]), 32'd1);
        tick();
        chk("t3_rf_we", 32'(rf_we), 32'd1);
        chk("t3_rf_waddr", 32'(rf_waddr), 32'd8);
        chk("t3_rf_wdata", rf_wdata, 32'hDEAD);
        chk("t3_busy8_clr", 32'(busy_mask[8]), 32'd0);

        // 4: fill under constant pipeline traffic, then drain in order
        $display("T4 fill to full under pipe traffic, then drain");
        pipe_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pipe_waddr = 5'(1 + i); pipe_wdata = 32'h100 + 32'(i);
            lu_valid = 1'b1; lu_waddr = 5'(10 + i); lu_wdata = 32'hA0 + 32'(i);
            tick();
        end
        lu_waddr = 5'd14; lu_wdata = 32'hA4;   // held while full
        pipe_waddr = 5'd4; pipe_wdata = 32'h104;
        tick();
        chk("t4_full_ready", 32'(lu_ready), 32'd0);
        chk("t4_full_count", 32'(fifo_count), 32'd4);
        chk("t4_pipe_waddr", 32'(rf_waddr), 32'd4);
        pipe_we = 1'b0;
        tick();                                 // pop $10, no push on full
        chk("t4_drain0_waddr", 32'(rf_waddr), 32'd10);
        chk("t4_drain0_wdata", rf_wdata, 32'hA0);
        chk("t4_full_pop_count", 32'(fifo_count), 32'd3);
        tick();                                 // pop $11, push $14
        lu_valid = 1'b0;
        chk("t4_drain1_waddr", 32'(rf_waddr), 32'd11);
        chk("t4_pushpop_count", 32'(fifo_count), 32'd3);
        repeat (3) tick();
        chk("t4_last_waddr", 32'(rf_waddr), 32'd14);
        chk("t4_empty", 32'(fifo_count), 32'd0);

        // 5: pipeline write to $0 does not block the FIFO; lu $0 drains silently
        $display("T5 $0 handling");
        pipe_we = 1'b1; pipe_waddr = 5'd6; pipe_wdata = 32'h66;
        lu_valid = 1'b1; lu_waddr = 5'd3; lu_wdata = 32'h77;
        tick();
        pipe_waddr = 5'd0; pipe_wdata = 32'hBAD;
        lu_waddr = 5'd0; lu_wdata = 32'h55;
        tick();
        pipe_we = 1'b0; lu_valid = 1'b0;
        chk("t5_pop_we", 32'(rf_we), 32'd1);
        chk("t5_pop_waddr", 32'(rf_waddr), 32'd3);
        chk("t5_pop_wdata", rf_wdata, 32'h77);
        tick();
        chk("t5_zero_pop_we", 32'(rf_we), 32'd0);
        chk("t5_zero_count", 32'(fifo_count), 32'd0);

        // 6: scoreboard error, set-beats-clear, then reset mid-drain
        $display("T6 scoreboard and reset mid-drain");
        issue_valid = 1'b1; issue_waddr = 5'd9;
        tick();
        tick();
        issue_valid = 1'b0;
        chk("t6_sb_err", 32'(sb_err), 32'd1);
        lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h99;
        tick();
        lu_valid = 1'b0;
        issue_valid = 1'b1; issue_waddr = 5'd9;
        tick();
        issue_valid = 1'b0;
        chk("t6_pop9_waddr", 32'(rf_waddr), 32'd9);
        chk("t6_busy9_kept", 32'(busy_mask[9]), 32'd1);
        chk("t6_sb_err_sticky", 32'(sb_err), 32'd1);
        pipe_we = 1'b1; pipe_waddr = 5'd7; pipe_wdata = 32'h7;
        lu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lu_waddr = 5'(20 + i); lu_wdata = 32'hC0 + 32'(i);
            tick();
        end
        pipe_we = 1'b0; lu_valid = 1'b0;
        tick();
        chk("t6_mid_drain_count", 32'(fifo_count), 32'd2);
        rst = 1'b1;
        tick();
        chk("t6_rst_count", 32'(fifo_count), 32'd0);
        chk("t6_rst_we", 32'(rf_we), 32'd0);
        chk("t6_rst_busy", busy_mask, 32'd0);
        chk("t6_rst_err", 32'(sb_err), 32'd0);
        chk("t6_rst_ready", 32'(lu_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("t6_post_we", 32'(rf_we), 32'd0);
        chk("t6_post_count", 32'(fifo_count), 32'd0);
        chk("t6_post_ready", 32'(lu_ready), 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
